// File: rtl/reg_dump_reader_pkg.sv
// Shared types and size helpers for the register-file dump reader.
// Optional build macro: REG_DUMP_CHECKSUM_EN (appends an XOR checksum word).
package reg_dump_reader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SEND,
        ST_DONE,
        ST_CSUM
    } state_e;

    localparam int unsigned DEF_ADDR_WIDTH = 5;
    localparam int unsigned NUM_REGS       = 1 << DEF_ADDR_WIDTH;

`ifdef REG_DUMP_CHECKSUM_EN
    localparam int unsigned DUMP_WORDS = NUM_REGS + 1;
`else
    localparam int unsigned DUMP_WORDS = NUM_REGS;
`endif

    // Number of registers addressed by an address of the given width.
    function automatic int unsigned num_regs(input int unsigned addr_width);
        return 1 << addr_width;
    endfunction

endpackage

// File: rtl/reg_dump_reader.sv
// Sequential register-file dump reader: walks every register address,
// captures the read data and streams (address, data) pairs on a
// valid/ready port while holding the core's register writes.
// Optional build macro: REG_DUMP_CHECKSUM_EN adds a trailing XOR checksum word.
module reg_dump_reader
    import reg_dump_reader_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic [ADDR_WIDTH-1:0] rf_addr,
    input  logic [DATA_WIDTH-1:0] rf_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [ADDR_WIDTH-1:0] out_addr,
    output logic                  busy,
    output logic                  cpu_hold,
    output logic                  done
);

    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(num_regs(ADDR_WIDTH) - 1);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] idx_q, idx_d;
    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic [ADDR_WIDTH-1:0] out_addr_q, out_addr_d;
`ifdef REG_DUMP_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] csum_q, csum_d;
`endif

    logic handshake;
    assign handshake = out_valid_q && out_ready;

    // State, index and output-word registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_addr_q  <= '0;
`ifdef REG_DUMP_CHECKSUM_EN
            csum_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_addr_q  <= out_addr_d;
`ifdef REG_DUMP_CHECKSUM_EN
            csum_q      <= csum_d;
`endif
        end
    end

    // Next-state and next-word logic for the dump walk.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_addr_d  = out_addr_q;
`ifdef REG_DUMP_CHECKSUM_EN
        csum_d      = csum_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_LOAD;
                    idx_d   = '0;
`ifdef REG_DUMP_CHECKSUM_EN
                    csum_d  = '0;
`endif
                end
            end
            ST_LOAD: begin
                out_data_d  = rf_data;
                out_addr_d  = idx_q;
                out_valid_d = 1'b1;
`ifdef REG_DUMP_CHECKSUM_EN
                csum_d      = csum_q ^ rf_data;
`endif
                state_d     = ST_SEND;
            end
            ST_SEND: begin
                if (handshake) begin
                    out_valid_d = 1'b0;
                    if (idx_q == LAST_IDX) begin
`ifdef REG_DUMP_CHECKSUM_EN
                        // The checksum word follows immediately with no LOAD gap.
                        state_d     = ST_CSUM;
                        out_valid_d = 1'b1;
                        out_data_d  = csum_q;
                        out_addr_d  = '0;
`else
                        state_d     = ST_DONE;
`endif
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = ST_LOAD;
                    end
                end
            end
`ifdef REG_DUMP_CHECKSUM_EN
            ST_CSUM: begin
                if (handshake) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_DONE;
                end
            end
`endif
            ST_DONE: begin
                // Park the read address back at register 0 for the idle state.
                idx_d   = '0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d     = ST_IDLE;
                idx_d       = '0;
                out_valid_d = 1'b0;
            end
        endcase
    end

    assign rf_addr   = idx_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_addr  = out_addr_q;
    assign busy      = (state_q != ST_IDLE);
    assign cpu_hold  = busy;
    assign done      = (state_q == ST_DONE);

endmodule
